// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM between two requesters.
// Every access walks IDLE -> ACCESS -> DONE, so the RAM serves at most one access
// per three cycles. Simultaneous requests are settled round-robin, or in favour
// of port A when FIXED_PRIO is set. All outputs come straight from flops.
module ram_arbiter #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 8,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,

  // Port A: CPU load/store path
  input  logic              a_req_i,
  input  logic              a_we_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  output logic              a_gnt_o,
  output logic              a_done_o,
  output logic [DATA_W-1:0] a_rdata_o,

  // Port B: I/O engine
  input  logic              b_req_i,
  input  logic              b_we_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_wdata_i,
  output logic              b_gnt_o,
  output logic              b_done_o,
  output logic [DATA_W-1:0] b_rdata_o,

  // RAM side
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_we_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e state_q, state_d;

  // Owner of the transaction in flight (1 = B) and of the last completed one.
  logic owner_b_q, owner_b_d;
  logic last_b_q, last_b_d;

  logic any_req;
  logic pick_b;

  logic              a_gnt_q, a_gnt_d;
  logic              a_done_q, a_done_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic              b_gnt_q, b_gnt_d;
  logic              b_done_q, b_done_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;

  // Arbitration: a lone requester wins; a tie goes to A (fixed) or away from the last owner.
  always_comb begin
    any_req = a_req_i | b_req_i;
    if (a_req_i && b_req_i) begin
      pick_b = FIXED_PRIO ? 1'b0 : ~last_b_q;
    end else begin
      pick_b = b_req_i;
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: fixed three-step walk once a request has been accepted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d = StAccess;
        end
      end
      StAccess: state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output next-state logic: every output is a flop, so this computes its D input.
  always_comb begin
    owner_b_d   = owner_b_q;
    last_b_d    = last_b_q;
    a_gnt_d     = a_gnt_q;
    a_done_d    = a_done_q;
    a_rdata_d   = a_rdata_q;
    b_gnt_d     = b_gnt_q;
    b_done_d    = b_done_q;
    b_rdata_d   = b_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;

    case (state_q)
      StIdle: begin
        a_gnt_d  = 1'b0;
        b_gnt_d  = 1'b0;
        a_done_d = 1'b0;
        b_done_d = 1'b0;
        mem_we_d = 1'b0;
        // The winner's request is captured here and never looked at again.
        if (any_req) begin
          owner_b_d   = pick_b;
          a_gnt_d     = ~pick_b;
          b_gnt_d     = pick_b;
          mem_addr_d  = pick_b ? b_addr_i  : a_addr_i;
          mem_wdata_d = pick_b ? b_wdata_i : a_wdata_i;
          mem_we_d    = pick_b ? b_we_i    : a_we_i;
        end
      end
      StAccess: begin
        // RAM samples at the end of this cycle; write strobe lasts exactly one cycle.
        mem_we_d = 1'b0;
        a_done_d = ~owner_b_q;
        b_done_d = owner_b_q;
        // mem_we_q still reflects the transaction type during ACCESS.
        if (!mem_we_q) begin
          if (owner_b_q) begin
            b_rdata_d = mem_rdata_i;
          end else begin
            a_rdata_d = mem_rdata_i;
          end
        end
      end
      StDone: begin
        a_gnt_d  = 1'b0;
        b_gnt_d  = 1'b0;
        a_done_d = 1'b0;
        b_done_d = 1'b0;
        last_b_d = owner_b_q;
      end
      default: begin
        a_gnt_d  = 1'b0;
        b_gnt_d  = 1'b0;
        a_done_d = 1'b0;
        b_done_d = 1'b0;
        mem_we_d = 1'b0;
      end
    endcase
  end

  // Output and bookkeeping registers; reset clears everything and hands the first tie to A.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner_b_q   <= 1'b0;
      last_b_q    <= 1'b1;
      a_gnt_q     <= 1'b0;
      a_done_q    <= 1'b0;
      a_rdata_q   <= '0;
      b_gnt_q     <= 1'b0;
      b_done_q    <= 1'b0;
      b_rdata_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
    end else begin
      owner_b_q   <= owner_b_d;
      last_b_q    <= last_b_d;
      a_gnt_q     <= a_gnt_d;
      a_done_q    <= a_done_d;
      a_rdata_q   <= a_rdata_d;
      b_gnt_q     <= b_gnt_d;
      b_done_q    <= b_done_d;
      b_rdata_q   <= b_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
    end
  end

  assign a_gnt_o     = a_gnt_q;
  assign a_done_o    = a_done_q;
  assign a_rdata_o   = a_rdata_q;
  assign b_gnt_o     = b_gnt_q;
  assign b_done_o    = b_done_q;
  assign b_rdata_o   = b_rdata_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_we_o    = mem_we_q;

  // Structural invariants of the sequencing.
  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
    !(a_gnt_o && b_gnt_o));
  a_no_gnt_in_idle: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == StIdle) |-> !(a_gnt_o || b_gnt_o));
  a_we_only_in_access: assert property (@(posedge clk_i) disable iff (rst_i)
    mem_we_o |-> (state_q == StAccess));

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: instance 0 is round-robin, instance 1 fixed-priority,
// each with its own RAM model. Directed scenarios plus randomized traffic
// checked against a transaction/timeline reference model.
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic ram_init;

  always #5 clk = ~clk;

  logic       a_req [2];
  logic       a_we [2];
  logic [7:0] a_addr [2];
  logic [7:0] a_wdata [2];
  logic       a_gnt [2];
  logic       a_done [2];
  logic [7:0] a_rdata [2];
  logic       b_req [2];
  logic       b_we [2];
  logic [7:0] b_addr [2];
  logic [7:0] b_wdata [2];
  logic       b_gnt [2];
  logic       b_done [2];
  logic [7:0] b_rdata [2];
  logic [7:0] mem_addr [2];
  logic [7:0] mem_wdata [2];
  logic       mem_we [2];

  int checks = 0;
  int failures = 0;

  // Reference copy of each RAM's contents.
  logic [7:0] shadow [2][256];

  function automatic logic [7:0] init_val(input int k);
    return 8'((k * 37 + 11) & 255);
  endfunction

  for (genvar i = 0; i < 2; i++) begin : g_dut
    logic [7:0] ram [256];
    logic [7:0] mem_rdata;

    ram_arbiter #(
      .ADDR_W     (8),
      .DATA_W     (8),
      .FIXED_PRIO (i == 1)
    ) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .a_req_i     (a_req[i]),
      .a_we_i      (a_we[i]),
      .a_addr_i    (a_addr[i]),
      .a_wdata_i   (a_wdata[i]),
      .a_gnt_o     (a_gnt[i]),
      .a_done_o    (a_done[i]),
      .a_rdata_o   (a_rdata[i]),
      .b_req_i     (b_req[i]),
      .b_we_i      (b_we[i]),
      .b_addr_i    (b_addr[i]),
      .b_wdata_i   (b_wdata[i]),
      .b_gnt_o     (b_gnt[i]),
      .b_done_o    (b_done[i]),
      .b_rdata_o   (b_rdata[i]),
      .mem_addr_o  (mem_addr[i]),
      .mem_wdata_o (mem_wdata[i]),
      .mem_we_o    (mem_we[i]),
      .mem_rdata_i (mem_rdata)
    );

    // RAM writes on the rising edge that closes ACCESS.
    always @(posedge clk) begin
      if (ram_init) begin
        for (int k = 0; k < 256; k++) ram[k] <= init_val(k);
      end else if (mem_we[i]) begin
        ram[mem_addr[i]] <= mem_wdata[i];
      end
    end

    // Read data is clocked out mid-ACCESS, ready for the edge entering DONE.
    always @(negedge clk) mem_rdata <= ram[mem_addr[i]];
  end

  task automatic test_reset();
    logic [41:0] got;
    for (int d = 0; d < 2; d++) begin
      got = {a_gnt[d], a_done[d], a_rdata[d], b_gnt[d], b_done[d], b_rdata[d],
             mem_addr[d], mem_wdata[d], mem_we[d]};
      checks++;
      if (got !== '0) begin
        failures++;
        $display("FAIL reset_outputs dut%0d: got %h required 0", d, got);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      got = {a_gnt[d], a_done[d], a_rdata[d], b_gnt[d], b_done[d], b_rdata[d],
             mem_addr[d], mem_wdata[d], mem_we[d]};
      checks++;
      if (got !== '0) begin
        failures++;
        $display("FAIL idle_after_release dut%0d: got %h required 0", d, got);
      end
    end
  endtask

  task automatic test_single_read();
    bit seen;
    // Preload RAM[0x10] = 0x5A through port B.
    b_req[0] = 1'b1; b_we[0] = 1'b1; b_addr[0] = 8'h10; b_wdata[0] = 8'h5A;
    seen = 1'b0;
    for (int n = 0; n < 6 && !seen; n++) begin
      @(negedge clk);
      seen = b_done[0];
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL preload_done: got no b_done required b_done");
    end
    b_req[0] = 1'b0;
    shadow[0][8'h10] = 8'h5A;
    @(negedge clk);
    a_req[0] = 1'b1; a_we[0] = 1'b0; a_addr[0] = 8'h10; a_wdata[0] = 8'hEE;
    @(negedge clk);
    checks++;
    if ({a_gnt[0], a_done[0], b_gnt[0], b_done[0], mem_we[0], mem_addr[0]} !== {5'b10000, 8'h10})
    begin
      failures++;
      $display("FAIL read_access: gnt/done/bgnt/bdone/we=%b%b%b%b%b addr=%h required 10000 10",
               a_gnt[0], a_done[0], b_gnt[0], b_done[0], mem_we[0], mem_addr[0]);
    end
    @(negedge clk);
    checks++;
    if ({a_gnt[0], a_done[0], b_gnt[0], b_done[0], a_rdata[0], b_rdata[0]}
        !== {4'b1100, 8'h5A, 8'h00}) begin
      failures++;
      $display("FAIL read_done: gnt=%b done=%b bgnt=%b bdone=%b rdata=%h brdata=%h required 1 1 0 0 5a 00",
               a_gnt[0], a_done[0], b_gnt[0], b_done[0], a_rdata[0], b_rdata[0]);
    end
    a_req[0] = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_gnt[0], a_done[0], a_rdata[0]} !== {2'b00, 8'h5A}) begin
      failures++;
      $display("FAIL read_after: gnt=%b done=%b rdata=%h required 0 0 5a",
               a_gnt[0], a_done[0], a_rdata[0]);
    end
  endtask

  task automatic test_single_write();
    int we_cnt, done_cnt;
    bit seen;
    b_req[0] = 1'b1; b_we[0] = 1'b1; b_addr[0] = 8'h80; b_wdata[0] = 8'hC3;
    we_cnt = 0; done_cnt = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (mem_we[0]) begin
        we_cnt++;
        checks++;
        if ({mem_addr[0], mem_wdata[0]} !== 16'h80C3) begin
          failures++;
          $display("FAIL write_bus: addr=%h wdata=%h required 80 c3", mem_addr[0], mem_wdata[0]);
        end
      end
      if (b_done[0]) begin
        done_cnt++;
        checks++;
        if (b_rdata[0] !== 8'h00) begin
          failures++;
          $display("FAIL write_rdata_hold: got %h required 00", b_rdata[0]);
        end
        b_req[0] = 1'b0;
      end
    end
    b_req[0] = 1'b0;
    shadow[0][8'h80] = 8'hC3;
    checks++;
    if (we_cnt != 1 || done_cnt != 1) begin
      failures++;
      $display("FAIL write_pulses: we_cycles=%0d done_pulses=%0d required 1 1", we_cnt, done_cnt);
    end
    a_req[0] = 1'b1; a_we[0] = 1'b0; a_addr[0] = 8'h80;
    seen = 1'b0;
    for (int n = 0; n < 6 && !seen; n++) begin
      @(negedge clk);
      seen = a_done[0];
    end
    checks++;
    if (!seen || a_rdata[0] !== 8'hC3) begin
      failures++;
      $display("FAIL readback_80: done_seen=%0d rdata=%h required 1 c3", seen, a_rdata[0]);
    end
    a_req[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_input_change();
    a_req[0] = 1'b1; a_we[0] = 1'b0; a_addr[0] = 8'h20;
    @(negedge clk);
    checks++;
    if (mem_addr[0] !== 8'h20) begin
      failures++;
      $display("FAIL change_access_addr: got %h required 20", mem_addr[0]);
    end
    a_addr[0] = 8'h30;
    @(negedge clk);
    checks++;
    if ({a_done[0], mem_addr[0], a_rdata[0]} !== {1'b1, 8'h20, shadow[0][8'h20]}) begin
      failures++;
      $display("FAIL change_done: done=%b addr=%h rdata=%h required 1 20 %h",
               a_done[0], mem_addr[0], a_rdata[0], shadow[0][8'h20]);
    end
    a_req[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_write();
    bit seen;
    a_req[0] = 1'b1; a_we[0] = 1'b1; a_addr[0] = 8'h44; a_wdata[0] = 8'h99;
    @(negedge clk);
    checks++;
    if ({a_gnt[0], mem_we[0]} !== 2'b11) begin
      failures++;
      $display("FAIL midwrite_access: gnt=%b we=%b required 1 1", a_gnt[0], mem_we[0]);
    end
    b_req[0] = 1'b1; b_we[0] = 1'b0; b_addr[0] = 8'h10;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({mem_we[0], a_gnt[0], a_done[0]} !== 3'b000) begin
      failures++;
      $display("FAIL async_reset: we=%b gnt=%b done=%b required 0 0 0",
               mem_we[0], a_gnt[0], a_done[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_gnt[0], b_gnt[0], mem_we[0], mem_addr[0]} !== {3'b101, 8'h44}) begin
      failures++;
      $display("FAIL post_reset_tie: agnt=%b bgnt=%b we=%b addr=%h required 1 0 1 44",
               a_gnt[0], b_gnt[0], mem_we[0], mem_addr[0]);
    end
    @(negedge clk);
    a_req[0] = 1'b0;
    shadow[0][8'h44] = 8'h99;
    seen = 1'b0;
    for (int n = 0; n < 6 && !seen; n++) begin
      @(negedge clk);
      seen = b_done[0];
    end
    checks++;
    if (!seen || b_rdata[0] !== 8'h5A) begin
      failures++;
      $display("FAIL post_reset_b: done_seen=%0d rdata=%h required 1 5a", seen, b_rdata[0]);
    end
    b_req[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fixed_priority();
    int a_cnt;
    bit b_seen, seen;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    a_req[1] = 1'b1; a_we[1] = 1'b0; a_addr[1] = 8'h01;
    b_req[1] = 1'b1; b_we[1] = 1'b0; b_addr[1] = 8'h02;
    a_cnt = 0; b_seen = 1'b0;
    for (int n = 0; n < 20 && a_cnt < 4; n++) begin
      @(negedge clk);
      if (b_gnt[1]) b_seen = 1'b1;
      if (a_done[1]) a_cnt++;
    end
    a_req[1] = 1'b0;
    checks++;
    if (a_cnt != 4 || b_seen || a_rdata[1] !== shadow[1][1]) begin
      failures++;
      $display("FAIL fixed_a_wins: a_dones=%0d b_granted=%0d rdata=%h required 4 0 %h",
               a_cnt, b_seen, a_rdata[1], shadow[1][1]);
    end
    seen = 1'b0;
    for (int n = 0; n < 8 && !seen; n++) begin
      @(negedge clk);
      seen = b_done[1];
    end
    checks++;
    if (!seen || b_rdata[1] !== shadow[1][2]) begin
      failures++;
      $display("FAIL fixed_b_after_drop: done_seen=%0d rdata=%h required 1 %h",
               seen, b_rdata[1], shadow[1][2]);
    end
    b_req[1] = 1'b0;
    @(negedge clk);
  endtask

  // Randomized traffic vs. timeline model: a request accepted at edge s owns
  // the RAM after edges s and s+1, completes after edge s+1, and the arbiter
  // can accept again from edge s+3.
  task automatic run_traffic(input int d, input int ncyc, input int p_new, input bit both);
    bit fixed, busy, win_b, last_b, t_we, ra, rb;
    int s;
    logic [7:0] t_addr, t_wdata, exp_ar, exp_br;
    logic [4:0] got_c, exp_c;
    fixed = (d == 1);
    busy = 1'b0; win_b = 1'b0; last_b = 1'b1; t_we = 1'b0; s = 0;
    t_addr = '0; t_wdata = '0;
    a_req[d] = 1'b0; b_req[d] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_ar = '0; exp_br = '0;
    for (int k = 0; k < ncyc; k++) begin
      // Requesters: drop or reissue after done, otherwise maybe start a request.
      if (a_req[d] && a_done[d]) begin
        if (both || $urandom_range(0, 99) < 50) begin
          a_we[d] = 1'($urandom); a_addr[d] = 8'($urandom_range(0, 15));
          a_wdata[d] = 8'($urandom);
        end else a_req[d] = 1'b0;
      end else if (!a_req[d]) begin
        a_we[d] = 1'($urandom); a_addr[d] = 8'($urandom_range(0, 15));
        a_wdata[d] = 8'($urandom);
        if (both || $urandom_range(0, 99) < p_new) a_req[d] = 1'b1;
      end
      if (b_req[d] && b_done[d]) begin
        if (both || $urandom_range(0, 99) < 50) begin
          b_we[d] = 1'($urandom); b_addr[d] = 8'($urandom_range(0, 15));
          b_wdata[d] = 8'($urandom);
        end else b_req[d] = 1'b0;
      end else if (!b_req[d]) begin
        b_we[d] = 1'($urandom); b_addr[d] = 8'($urandom_range(0, 15));
        b_wdata[d] = 8'($urandom);
        if (both || $urandom_range(0, 99) < p_new) b_req[d] = 1'b1;
      end

      @(posedge clk);
      ra = a_req[d]; rb = b_req[d];
      if (busy) begin
        if (k == s + 1) begin
          if (t_we) shadow[d][t_addr] = t_wdata;
          else if (win_b) exp_br = shadow[d][t_addr];
          else exp_ar = shadow[d][t_addr];
        end else if (k == s + 2) begin
          busy = 1'b0;
          last_b = win_b;
        end
      end else if (ra || rb) begin
        win_b   = (ra && rb) ? (fixed ? 1'b0 : !last_b) : rb;
        t_we    = win_b ? b_we[d] : a_we[d];
        t_addr  = win_b ? b_addr[d] : a_addr[d];
        t_wdata = win_b ? b_wdata[d] : a_wdata[d];
        busy    = 1'b1;
        s       = k;
      end

      @(negedge clk);
      got_c = {a_gnt[d], b_gnt[d], a_done[d], b_done[d], mem_we[d]};
      exp_c = {busy && !win_b, busy && win_b, busy && (k == s + 1) && !win_b,
               busy && (k == s + 1) && win_b, busy && (k == s) && t_we};
      checks++;
      if (got_c !== exp_c) begin
        failures++;
        $display("FAIL traffic_ctrl dut%0d cyc%0d: agnt/bgnt/adone/bdone/we=%b required %b",
                 d, k, got_c, exp_c);
      end
      checks++;
      if (a_rdata[d] !== exp_ar || b_rdata[d] !== exp_br) begin
        failures++;
        $display("FAIL traffic_rdata dut%0d cyc%0d: a=%h b=%h required a=%h b=%h",
                 d, k, a_rdata[d], b_rdata[d], exp_ar, exp_br);
      end
      if (busy) begin
        checks++;
        if (mem_addr[d] !== t_addr || (t_we && mem_wdata[d] !== t_wdata)) begin
          failures++;
          $display("FAIL traffic_bus dut%0d cyc%0d: addr=%h wdata=%h required addr=%h wdata=%h",
                   d, k, mem_addr[d], mem_wdata[d], t_addr, t_wdata);
        end
      end
    end
    a_req[d] = 1'b0;
    b_req[d] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    ram_init = 1'b1;
    for (int d = 0; d < 2; d++) begin
      a_req[d] = 1'b0; a_we[d] = 1'b0; a_addr[d] = '0; a_wdata[d] = '0;
      b_req[d] = 1'b0; b_we[d] = 1'b0; b_addr[d] = '0; b_wdata[d] = '0;
      for (int k = 0; k < 256; k++) shadow[d][k] = init_val(k);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    ram_init = 1'b0;

    test_reset();
    test_single_read();
    test_single_write();
    test_input_change();
    test_reset_mid_write();
    run_traffic(0, 60, 100, 1'b1);   // both held: strict A/B alternation
    test_fixed_priority();
    run_traffic(0, 150, 40, 1'b0);
    run_traffic(1, 150, 40, 1'b0);
    run_traffic(1, 40, 100, 1'b1);   // both held on fixed priority: A only

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
